// File: rtl/barcode_pkg.sv
// Shared definitions for the barcode LED sequencer: state encoding, width helpers
// and the legality check on timing parameters.
package barcode_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WARMUP   = 3'd1;
    localparam logic [2:0] ST_ENABLE   = 3'd2;
    localparam logic [2:0] ST_BIT      = 3'd3;
    localparam logic [2:0] ST_GAP      = 3'd4;
    localparam logic [2:0] ST_COOLDOWN = 3'd5;

    function automatic int nbw(input int dw);
        return $clog2(dw + 1);
    endfunction

    function automatic int cnt_w(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return $clog2(m + 1);
    endfunction

    function automatic bit params_ok(input int dw, input int settle, input int bitc,
                                     input int t1, input int t0, input int gap);
        return (dw >= 1) && (settle >= 1) && (gap >= 1) &&
               (t0 >= 1) && (t0 < t1) && (t1 < bitc);
    endfunction

endpackage

// File: rtl/barcode_bit_timer.sv
// Cell timer: counts clocks within a bit cell (or warm-up/gap interval) and
// gives the PWM level for the cycle being entered, so the parent can register it.
module barcode_bit_timer #(
    parameter int CW = 8,
    parameter int T1 = 6,
    parameter int T0 = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [CW-1:0] tc,
    input  logic          bit_val,
    output logic          pwm,
    output logic          cell_end
);

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;

    assign cnt_nxt  = load ? '0 : cnt + CW'(1);
    assign cell_end = (cnt == tc - CW'(1));
    assign pwm      = (cnt_nxt < (bit_val ? CW'(T1) : CW'(T0)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            cnt <= cnt_nxt;
        end
    end

endmodule

// File: rtl/barcode_seq_ctrl.sv
// Barcode LED driver sequencer: bias warm-up, enable, MSB-first PWM bit cells,
// inter-frame gaps and ordered shutdown, with abort and registered outputs.
module barcode_seq_ctrl import barcode_pkg::*; #(
    parameter int DATA_W      = 32,
    parameter int SETTLE_CYC  = 1200,
    parameter int BIT_CYC     = 240,
    parameter int T1_HIGH_CYC = 180,
    parameter int T0_HIGH_CYC = 60,
    parameter int GAP_CYC     = 480,
    localparam int NBW        = nbw(DATA_W)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] data,
    input  logic [NBW-1:0]    nbits,
    input  logic [3:0]        rpt,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic              curren,
    output logic              barcode_en,
    output logic              barcode_pwm
);

    localparam int CW = cnt_w(SETTLE_CYC, BIT_CYC, GAP_CYC);
    localparam int IW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    if (!params_ok(DATA_W, SETTLE_CYC, BIT_CYC, T1_HIGH_CYC, T0_HIGH_CYC, GAP_CYC)) begin : g_param_err
        $error("barcode_seq_ctrl: illegal timing parameters");
    end

    logic [2:0]        state, state_nxt;
    logic [IW-1:0]     idx, idx_nxt;
    logic [3:0]        frames, frames_nxt;
    logic [NBW-1:0]    nbits_q;
    logic [DATA_W-1:0] data_q;
    logic [CW-1:0]     tc;
    logic              load, cap, done_nxt, aborted_nxt;
    logic              cell_end, t_pwm, bit_val, nbits_ok;

    assign nbits_ok = (nbits != '0) && (nbits <= NBW'(DATA_W));
    assign bit_val  = data_q[idx_nxt];

    always_comb begin
        case (state)
            ST_WARMUP: tc = CW'(SETTLE_CYC);
            ST_GAP:    tc = CW'(GAP_CYC);
            default:   tc = CW'(BIT_CYC);
        endcase
    end

    barcode_bit_timer #(
        .CW (CW),
        .T1 (T1_HIGH_CYC),
        .T0 (T0_HIGH_CYC)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .tc       (tc),
        .bit_val  (bit_val),
        .pwm      (t_pwm),
        .cell_end (cell_end)
    );

    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        frames_nxt  = frames;
        load        = 1'b0;
        cap         = 1'b0;
        done_nxt    = 1'b0;
        aborted_nxt = 1'b0;
        case (state)
            ST_IDLE: begin
                load = 1'b1;
                if (start) begin
                    if (nbits_ok) begin
                        state_nxt  = ST_WARMUP;
                        cap        = 1'b1;
                        frames_nxt = rpt;
                    end else begin
                        done_nxt = 1'b1;
                    end
                end
            end
            ST_WARMUP: begin
                if (cell_end) state_nxt = ST_ENABLE;
            end
            ST_ENABLE: begin
                state_nxt = ST_BIT;
                idx_nxt   = IW'(nbits_q - NBW'(1));
                load      = 1'b1;
            end
            ST_BIT: begin
                if (cell_end) begin
                    load = 1'b1;
                    if (idx == '0) begin
                        state_nxt = (frames != '0) ? ST_GAP : ST_COOLDOWN;
                    end else begin
                        idx_nxt = idx - IW'(1);
                    end
                end
            end
            ST_GAP: begin
                if (cell_end) begin
                    state_nxt  = ST_BIT;
                    idx_nxt    = IW'(nbits_q - NBW'(1));
                    frames_nxt = frames - 4'd1;
                    load       = 1'b1;
                end
            end
            ST_COOLDOWN: begin
                state_nxt = ST_IDLE;
                done_nxt  = 1'b1;
            end
            default: state_nxt = ST_IDLE;
        endcase
        // Abort overrides everything outside IDLE, including a completing COOLDOWN.
        if (abort && (state != ST_IDLE)) begin
            state_nxt   = ST_IDLE;
            load        = 1'b1;
            done_nxt    = 1'b0;
            aborted_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (cap) begin
            data_q  <= data;
            nbits_q <= nbits;
        end
    end

    // Outputs are decoded from the next state so they line up with the state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            idx         <= '0;
            frames      <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            aborted     <= 1'b0;
            curren      <= 1'b0;
            barcode_en  <= 1'b0;
            barcode_pwm <= 1'b0;
        end else begin
            state       <= state_nxt;
            idx         <= idx_nxt;
            frames      <= frames_nxt;
            busy        <= (state_nxt != ST_IDLE);
            curren      <= (state_nxt != ST_IDLE);
            barcode_en  <= (state_nxt == ST_ENABLE) || (state_nxt == ST_BIT) ||
                           (state_nxt == ST_GAP);
            barcode_pwm <= (state_nxt == ST_BIT) && t_pwm;
            done        <= done_nxt;
            aborted     <= aborted_nxt;
        end
    end

endmodule

// File: tb/tb_barcode_seq_ctrl.sv
// Scoreboard bench for barcode_seq_ctrl: per-cycle expected output vectors are
// queued when a case is launched and a negedge monitor pops and compares them.
module tb_barcode_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] data = '0;
    logic [3:0] nbits = '0;
    logic [3:0] rpt = '0;
    logic       abort = 1'b0;
    logic       busy, done, aborted, curren, barcode_en, barcode_pwm;

    barcode_seq_ctrl #(
        .DATA_W      (8),
        .SETTLE_CYC  (4),
        .BIT_CYC     (8),
        .T1_HIGH_CYC (6),
        .T0_HIGH_CYC (2),
        .GAP_CYC     (5)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .data        (data),
        .nbits       (nbits),
        .rpt         (rpt),
        .abort       (abort),
        .busy        (busy),
        .done        (done),
        .aborted     (aborted),
        .curren      (curren),
        .barcode_en  (barcode_en),
        .barcode_pwm (barcode_pwm)
    );

    always #5 clk = ~clk;

    // Vector order: {busy, done, aborted, curren, barcode_en, barcode_pwm}
    logic [5:0] exp_q[$];
    string      tag = "none";
    int         tag_cyc = 0;
    int         n_cmp = 0;
    int         n_err = 0;
    int         cur_lo[$], cur_hi[$], en_lo[$], en_hi[$], pw_lo[$], pw_hi[$], dn[$], ab[$];

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [5:0] e;
            logic [5:0] g;
            e = exp_q.pop_front();
            g = {busy, done, aborted, curren, barcode_en, barcode_pwm};
            n_cmp++;
            if (g !== e) begin
                n_err++;
                $display("FAIL %s cycle %0d: got {busy,done,aborted,curren,en,pwm}=%b required %b",
                         tag, tag_cyc, g, e);
            end
            tag_cyc++;
        end
    end

    task automatic clear_prof();
        cur_lo.delete(); cur_hi.delete(); en_lo.delete(); en_hi.delete();
        pw_lo.delete();  pw_hi.delete();  dn.delete();    ab.delete();
    endtask

    // Hand-derived single-frame waveform for data=101b, nbits=3, rpt=0, start in cycle o.
    task automatic add_case1(input int o);
        cur_lo.push_back(1 + o);  cur_hi.push_back(30 + o);
        en_lo.push_back(5 + o);   en_hi.push_back(29 + o);
        pw_lo.push_back(6 + o);   pw_hi.push_back(11 + o);
        pw_lo.push_back(14 + o);  pw_hi.push_back(15 + o);
        pw_lo.push_back(22 + o);  pw_hi.push_back(27 + o);
        dn.push_back(31 + o);
    endtask

    task automatic push_prof(input string name, input int last);
        tag = name;
        tag_cyc = 0;
        for (int c = 0; c <= last; c++) begin
            logic b_cur, b_en, b_pw, b_dn, b_ab;
            b_cur = 1'b0; b_en = 1'b0; b_pw = 1'b0; b_dn = 1'b0; b_ab = 1'b0;
            foreach (cur_lo[i]) if (c >= cur_lo[i] && c <= cur_hi[i]) b_cur = 1'b1;
            foreach (en_lo[i])  if (c >= en_lo[i]  && c <= en_hi[i])  b_en  = 1'b1;
            foreach (pw_lo[i])  if (c >= pw_lo[i]  && c <= pw_hi[i])  b_pw  = 1'b1;
            foreach (dn[i])     if (c == dn[i]) b_dn = 1'b1;
            foreach (ab[i])     if (c == ab[i]) b_ab = 1'b1;
            exp_q.push_back({b_cur, b_dn, b_ab, b_cur, b_en, b_pw});
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start(input logic [7:0] d, input logic [3:0] n, input logic [3:0] r);
        start = 1'b1; data = d; nbits = n; rpt = r;
        wait_cycles(1);
        start = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 300) begin
            wait_cycles(1);
            guard++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain %s: %0d expected cycles left unchecked, required 0", tag, exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        // Reset state
        wait_cycles(1);
        clear_prof();
        push_prof("reset", 2);
        wait_cycles(3);
        rst_n = 1'b1;
        wait_cycles(2);

        // Case 1: single frame 101b
        clear_prof(); add_case1(0);
        push_prof("case1_frame101", 33);
        pulse_start(8'b0000_0101, 4'd3, 4'd0);
        drain();

        // Case 2: single '1' bit, three frames with gaps
        clear_prof();
        cur_lo.push_back(1); cur_hi.push_back(40);
        en_lo.push_back(5);  en_hi.push_back(39);
        pw_lo.push_back(6);  pw_hi.push_back(11);
        pw_lo.push_back(19); pw_hi.push_back(24);
        pw_lo.push_back(32); pw_hi.push_back(37);
        dn.push_back(41);
        push_prof("case2_repeat", 44);
        pulse_start(8'b0000_0001, 4'd1, 4'd2);
        drain();

        // Case 3: abort in cycle 18, restart in cycle 19
        clear_prof();
        cur_lo.push_back(1); cur_hi.push_back(18);
        en_lo.push_back(5);  en_hi.push_back(18);
        pw_lo.push_back(6);  pw_hi.push_back(11);
        pw_lo.push_back(14); pw_hi.push_back(15);
        ab.push_back(19);
        add_case1(19);
        push_prof("case3_abort", 53);
        pulse_start(8'b0000_0101, 4'd3, 4'd0);
        wait_cycles(17);
        abort = 1'b1;
        wait_cycles(1);
        abort = 1'b0;
        pulse_start(8'b0000_0101, 4'd3, 4'd0);
        drain();

        // Case 4: nbits=0 gives only done; a lone abort in IDLE does nothing
        clear_prof();
        dn.push_back(1);
        push_prof("case4_nbits0", 5);
        pulse_start(8'hff, 4'd0, 4'd0);
        abort = 1'b1;
        wait_cycles(1);
        abort = 1'b0;
        drain();

        // Case 4b: nbits above DATA_W is also rejected
        clear_prof();
        dn.push_back(1);
        push_prof("case4b_nbits9", 4);
        pulse_start(8'hff, 4'd9, 4'd0);
        drain();

        // Case 5: second start while busy is ignored
        clear_prof(); add_case1(0);
        push_prof("case5_start_busy", 33);
        pulse_start(8'b0000_0101, 4'd3, 4'd0);
        wait_cycles(9);
        pulse_start(8'b1111_1111, 4'd8, 4'd3);
        drain();

        // Case 7: start and abort together in IDLE, start wins
        clear_prof(); add_case1(0);
        push_prof("case7_start_abort", 33);
        abort = 1'b1;
        pulse_start(8'b0000_0101, 4'd3, 4'd0);
        abort = 1'b0;
        drain();

        // Case 6: async reset in cycle 12, then a clean sequence
        clear_prof();
        cur_lo.push_back(1); cur_hi.push_back(11);
        en_lo.push_back(5);  en_hi.push_back(11);
        pw_lo.push_back(6);  pw_hi.push_back(11);
        push_prof("case6_reset", 17);
        pulse_start(8'b0000_0101, 4'd3, 4'd0);
        wait_cycles(11);
        #1 rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, aborted, curren, barcode_en, barcode_pwm} !== 6'b0) begin
            n_err++;
            $display("FAIL case6_async_clear: got %b required 000000",
                     {busy, done, aborted, curren, barcode_en, barcode_pwm});
        end
        wait_cycles(3);
        rst_n = 1'b1;
        drain();

        clear_prof(); add_case1(0);
        push_prof("case6_after_reset", 33);
        pulse_start(8'b0000_0101, 4'd3, 4'd0);
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
